// File: rtl/demux_pkg.sv
// Shared definitions for the stream demultiplexer: steering modes and the
// round-robin pointer increment.
package demux_pkg;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

    // Advance a channel pointer by one, wrapping from nch-1 back to 0.
    // nch need not be a power of two, so the wrap is explicit.
    function automatic logic [31:0] wrap_inc(input logic [31:0] ptr, input logic [31:0] nch);
        if (ptr >= (nch - 32'd1)) begin
            return 32'd0;
        end else begin
            return ptr + 32'd1;
        end
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register for a single output channel. Data reads as
// zero whenever the slot is empty; a load in the same cycle as a drain
// keeps the slot full with the new beat.
module demux_slot #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    // Slot state: load takes priority over drain, drain empties and zeroes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drain && valid) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            valid <= valid;
            data  <= data;
        end
    end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-NCH stream demultiplexer with per-channel backpressure.
// Beats are steered by in_addr or by a round-robin pointer; beats addressed
// past the last channel are swallowed and flagged on a sticky error bit.
module stream_demux
    import demux_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 4,
    localparam int AW    = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [AW-1:0]        in_addr,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [NCH*WIDTH-1:0] out_data,
    output logic [NCH-1:0]       out_valid,
    input  logic [NCH-1:0]       out_ready,
    output logic [AW-1:0]        rr_ptr,
    output logic                 drop_err,
    input  logic                 err_clr
);

    // Address space rounded up to a power of two so any tgt value indexes safely.
    localparam int NSLOT = 1 << AW;

    logic [AW-1:0]    tgt_s;
    logic             tgt_legal_s;
    logic             accept_s;
    logic [NSLOT-1:0] ov_pad_s;
    logic [NSLOT-1:0] ordy_pad_s;
    logic [NCH-1:0]   load_s;
    logic [NCH-1:0]   drain_s;
    logic [AW-1:0]    rr_ptr_r;
    logic             drop_err_r;

    assign rr_ptr   = rr_ptr_r;
    assign drop_err = drop_err_r;
    assign drain_s  = out_valid & out_ready;
    assign accept_s = in_valid && in_ready;

    // Target channel and its legality; only addressed mode can exceed NCH-1.
    always_comb begin
        tgt_s = in_addr;
        if (mode == MODE_RR) begin
            tgt_s = rr_ptr_r;
        end else begin
            tgt_s = in_addr;
        end
        tgt_legal_s = (32'(tgt_s) < 32'(NCH));
    end

    // Ready: the target slot is empty or is being drained; illegal beats are always taken.
    always_comb begin
        ov_pad_s              = '0;
        ordy_pad_s            = '0;
        ov_pad_s[NCH-1:0]     = out_valid;
        ordy_pad_s[NCH-1:0]   = out_ready;
        in_ready              = 1'b1;
        if (tgt_legal_s) begin
            in_ready = !ov_pad_s[tgt_s] || ordy_pad_s[tgt_s];
        end else begin
            in_ready = 1'b1;
        end
    end

    // One-hot load strobe toward the slot chosen by the target.
    always_comb begin
        load_s = '0;
        for (int k = 0; k < NCH; k++) begin
            load_s[k] = accept_s && tgt_legal_s && (tgt_s == AW'(k));
        end
    end

    // Round-robin pointer moves only on an accepted beat in round-robin mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if ((mode == MODE_RR) && accept_s) begin
            rr_ptr_r <= AW'(wrap_inc(32'(rr_ptr_r), 32'(NCH)));
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // Sticky drop flag; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_err_r <= 1'b0;
        end else if (accept_s && !tgt_legal_s) begin
            drop_err_r <= 1'b1;
        end else if (err_clr) begin
            drop_err_r <= 1'b0;
        end else begin
            drop_err_r <= drop_err_r;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load_s[k]),
            .load_data (in_data),
            .drain     (drain_s[k]),
            .data      (out_data[k*WIDTH +: WIDTH]),
            .valid     (out_valid[k])
        );
    end

endmodule
